// File: rtl/bm_concat_byte_serializer.sv
// Byte serializer for concatenated words: accepts one BITS-wide word over valid/ready
// and emits it MSB byte first on a back-pressured byte stream, counting completed words.
module bm_concat_byte_serializer #(
    parameter int BITS  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [BITS-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [CNT_W-1:0] word_count
);
    localparam int NB = BITS / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    // state | meaning
    // IDLE  | no word held, ready to accept
    // SEND  | presenting byte r_sr[BITS-1 -: 8], r_cnt bytes remain after it
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           r_state;
    logic [BITS-1:0]  r_sr;
    logic [CW-1:0]    r_cnt;
    logic [CNT_W-1:0] r_word_count;

    logic w_last_byte;
    logic w_accept;
    logic w_emit;

    assign w_last_byte = (r_cnt == '0);
    assign out_valid   = (r_state == SEND);
    assign out_byte    = r_sr[BITS-1 -: 8];
    assign out_last    = out_valid && w_last_byte;
    // Accepting during the final emit lets the next word follow with no bubble.
    assign in_ready    = (r_state == IDLE) || (out_last && out_ready);
    assign w_accept    = in_valid && in_ready;
    assign w_emit      = out_valid && out_ready;
    assign word_count  = r_word_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_sr         <= '0;
            r_cnt        <= '0;
            r_word_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sr    <= in_data;
                        r_cnt   <= CW'(NB - 1);
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (w_emit) begin
                        if (!w_last_byte) begin
                            r_sr  <= r_sr << 8;
                            r_cnt <= r_cnt - 1'b1;
                        end else begin
                            r_word_count <= r_word_count + 1'b1;
                            if (w_accept) begin
                                r_sr    <= in_data;
                                r_cnt   <= CW'(NB - 1);
                                r_state <= SEND;
                            end else begin
                                r_state <= IDLE;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bm_concat_byte_serializer.sv
// Bench for bm_concat_byte_serializer: byte-queue reference model for the 32-bit/16-bit
// instance, plus a CNT_W=2 instance for counter wrap and mid-word reset.
module tb_bm_concat_byte_serializer;
    localparam int NB = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [15:0] word_count;

    logic        rst2_n;
    logic [31:0] in_data2;
    logic        in_valid2;
    logic        in_ready2;
    logic [7:0]  out_byte2;
    logic        out_valid2;
    logic        out_ready2;
    logic        out_last2;
    logic [1:0]  word_count2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bytes still owed to the sink, in order, and words completed.
    logic [7:0]  m_q[$];
    logic [15:0] m_cnt = '0;

    bm_concat_byte_serializer #(.BITS(32), .CNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_byte(out_byte), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .word_count(word_count)
    );

    bm_concat_byte_serializer #(.BITS(32), .CNT_W(2)) dut2 (
        .clock(clock), .reset_n(rst2_n), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .out_byte(out_byte2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_last(out_last2), .word_count(word_count2)
    );

    always #5 clock = ~clock;

    function automatic bit m_valid();
        return m_q.size() != 0;
    endfunction

    function automatic logic [7:0] m_byte();
        return (m_q.size() != 0) ? m_q[0] : 8'h00;
    endfunction

    function automatic bit m_last();
        return m_q.size() == 1;
    endfunction

    function automatic bit m_rdy();
        return (m_q.size() == 0) || (m_q.size() == 1 && out_ready == 1'b1);
    endfunction

    task automatic drive(input bit v, input logic [31:0] d, input bit r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
    endtask

    // Advance one clock and apply both handshakes to the model.
    task automatic step(output bit acc);
        bit emit;
        bit was_last;
        @(posedge clock);
        acc      = in_valid && m_rdy();
        emit     = m_valid() && out_ready;
        was_last = m_last();
        if (emit) begin
            void'(m_q.pop_front());
            if (was_last) m_cnt++;
        end
        if (acc) begin
            for (int b = NB - 1; b >= 0; b--) m_q.push_back(in_data[8*b +: 8]);
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; rst2_n = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1; rst2_n = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset out_last got %b exp 0", out_last); end
        n_checks++; if (word_count !== 16'd0) begin n_fail++; $display("FAIL reset word_count got %0d exp 0", word_count); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready got %b exp 1", in_ready); end
        n_checks++; if (out_byte !== 8'h00) begin n_fail++; $display("FAIL reset out_byte got %h exp 00", out_byte); end
    endtask

    task automatic test_basic();
        bit acc;
        for (int i = 0; i < 6; i++) begin
            drive(i == 0, (i == 0) ? 32'hA1B2C3D4 : 32'h0, 1'b1);
            n_checks++; if (out_valid !== m_valid()) begin n_fail++; $display("FAIL basic out_valid cyc %0d got %b exp %b", i, out_valid, m_valid()); end
            if (m_valid()) begin n_checks++; if (out_byte !== m_byte()) begin n_fail++; $display("FAIL basic out_byte cyc %0d got %h exp %h", i, out_byte, m_byte()); end end
            n_checks++; if (out_last !== m_last()) begin n_fail++; $display("FAIL basic out_last cyc %0d got %b exp %b", i, out_last, m_last()); end
            n_checks++; if (in_ready !== m_rdy()) begin n_fail++; $display("FAIL basic in_ready cyc %0d got %b exp %b", i, in_ready, m_rdy()); end
            n_checks++; if (word_count !== m_cnt) begin n_fail++; $display("FAIL basic word_count cyc %0d got %0d exp %0d", i, word_count, m_cnt); end
            step(acc);
        end
        n_checks++; if (word_count !== 16'd1) begin n_fail++; $display("FAIL basic final_count got %0d exp 1", word_count); end
    endtask

    task automatic test_backpressure();
        bit acc;
        for (int i = 0; i < 10; i++) begin
            drive(i == 0, (i == 0) ? 32'hA1B2C3D4 : 32'h0, !(i >= 2 && i <= 4));
            n_checks++; if (out_valid !== m_valid()) begin n_fail++; $display("FAIL bp out_valid cyc %0d got %b exp %b", i, out_valid, m_valid()); end
            if (m_valid()) begin n_checks++; if (out_byte !== m_byte()) begin n_fail++; $display("FAIL bp out_byte cyc %0d got %h exp %h", i, out_byte, m_byte()); end end
            n_checks++; if (out_last !== m_last()) begin n_fail++; $display("FAIL bp out_last cyc %0d got %b exp %b", i, out_last, m_last()); end
            n_checks++; if (in_ready !== m_rdy()) begin n_fail++; $display("FAIL bp in_ready cyc %0d got %b exp %b", i, in_ready, m_rdy()); end
            n_checks++; if (word_count !== m_cnt) begin n_fail++; $display("FAIL bp word_count cyc %0d got %0d exp %0d", i, word_count, m_cnt); end
            if (i >= 2 && i <= 5) begin
                n_checks++; if (out_byte !== 8'hB2) begin n_fail++; $display("FAIL bp held_byte cyc %0d got %h exp b2", i, out_byte); end
            end
            step(acc);
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        for (int i = 0; i < 10; i++) begin
            drive(i == 0 || i == 4, (i == 0) ? 32'hA1B2C3D4 : 32'h01020304, 1'b1);
            n_checks++; if (out_valid !== m_valid()) begin n_fail++; $display("FAIL b2b out_valid cyc %0d got %b exp %b", i, out_valid, m_valid()); end
            if (m_valid()) begin n_checks++; if (out_byte !== m_byte()) begin n_fail++; $display("FAIL b2b out_byte cyc %0d got %h exp %h", i, out_byte, m_byte()); end end
            n_checks++; if (out_last !== m_last()) begin n_fail++; $display("FAIL b2b out_last cyc %0d got %b exp %b", i, out_last, m_last()); end
            n_checks++; if (in_ready !== m_rdy()) begin n_fail++; $display("FAIL b2b in_ready cyc %0d got %b exp %b", i, in_ready, m_rdy()); end
            n_checks++; if (word_count !== m_cnt) begin n_fail++; $display("FAIL b2b word_count cyc %0d got %0d exp %0d", i, word_count, m_cnt); end
            if (i == 4) begin
                n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b ready_on_last got %b exp 1", in_ready); end
            end
            if (i == 5) begin
                n_checks++; if (out_byte !== 8'h01 || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b no_gap got %h/%b exp 01/1", out_byte, out_valid); end
            end
            step(acc);
        end
        n_checks++; if (word_count !== 16'd4) begin n_fail++; $display("FAIL b2b final_count got %0d exp 4", word_count); end
    endtask

    task automatic test_hold_input();
        bit acc;
        bit pend = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (i == 2) pend = 1'b1;
            drive(i == 0 || pend, (i == 0) ? 32'hCAFEBABE : 32'h11223344, 1'b1);
            n_checks++; if (out_valid !== m_valid()) begin n_fail++; $display("FAIL hold out_valid cyc %0d got %b exp %b", i, out_valid, m_valid()); end
            if (m_valid()) begin n_checks++; if (out_byte !== m_byte()) begin n_fail++; $display("FAIL hold out_byte cyc %0d got %h exp %h", i, out_byte, m_byte()); end end
            n_checks++; if (out_last !== m_last()) begin n_fail++; $display("FAIL hold out_last cyc %0d got %b exp %b", i, out_last, m_last()); end
            n_checks++; if (in_ready !== m_rdy()) begin n_fail++; $display("FAIL hold in_ready cyc %0d got %b exp %b", i, in_ready, m_rdy()); end
            n_checks++; if (word_count !== m_cnt) begin n_fail++; $display("FAIL hold word_count cyc %0d got %0d exp %0d", i, word_count, m_cnt); end
            if (i == 2 || i == 3) begin
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold busy_ready cyc %0d got %b exp 0", i, in_ready); end
            end
            step(acc);
            if (acc && i > 0) pend = 1'b0;
        end
        n_checks++; if (word_count !== 16'd6) begin n_fail++; $display("FAIL hold final_count got %0d exp 6", word_count); end
    endtask

    task automatic test_random();
        bit          acc;
        bit          pend = 1'b0;
        logic [31:0] w = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend && $urandom_range(0, 2) != 0) begin
                pend = 1'b1;
                w    = $urandom;
            end
            drive(pend && i < 380, pend ? w : $urandom, (i >= 380) || ($urandom_range(0, 3) != 0));
            n_checks++; if (out_valid !== m_valid()) begin n_fail++; $display("FAIL rand out_valid cyc %0d got %b exp %b", i, out_valid, m_valid()); end
            if (m_valid()) begin n_checks++; if (out_byte !== m_byte()) begin n_fail++; $display("FAIL rand out_byte cyc %0d got %h exp %h", i, out_byte, m_byte()); end end
            n_checks++; if (out_last !== m_last()) begin n_fail++; $display("FAIL rand out_last cyc %0d got %b exp %b", i, out_last, m_last()); end
            n_checks++; if (in_ready !== m_rdy()) begin n_fail++; $display("FAIL rand in_ready cyc %0d got %b exp %b", i, in_ready, m_rdy()); end
            n_checks++; if (word_count !== m_cnt) begin n_fail++; $display("FAIL rand word_count cyc %0d got %0d exp %0d", i, word_count, m_cnt); end
            step(acc);
            if (acc) pend = 1'b0;
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rand drained got %b exp 0", out_valid); end
    endtask

    task automatic test_count_wrap_reset();
        logic [1:0] exp_cnt;
        for (int k = 0; k < 5; k++) begin
            in_valid2  = 1'b1;
            in_data2   = $urandom;
            out_ready2 = 1'b1;
            @(posedge clock); #1;
            in_valid2 = 1'b0;
            repeat (NB) @(posedge clock);
            @(negedge clock);
            exp_cnt = 2'(k + 1);
            n_checks++; if (word_count2 !== exp_cnt) begin n_fail++; $display("FAIL wrap word_count word %0d got %0d exp %0d", k, word_count2, exp_cnt); end
        end
        in_valid2 = 1'b1;
        in_data2  = 32'hDEADBEEF;
        @(posedge clock); #1;
        in_valid2 = 1'b0;
        @(posedge clock);
        @(negedge clock);
        n_checks++; if (out_valid2 !== 1'b1 || out_byte2 !== 8'hAD) begin n_fail++; $display("FAIL midreset pre got %b/%h exp 1/ad", out_valid2, out_byte2); end
        rst2_n = 1'b0;
        #1;
        n_checks++; if (out_valid2 !== 1'b0) begin n_fail++; $display("FAIL midreset out_valid got %b exp 0", out_valid2); end
        n_checks++; if (word_count2 !== 2'd0) begin n_fail++; $display("FAIL midreset word_count got %0d exp 0", word_count2); end
        n_checks++; if (out_last2 !== 1'b0) begin n_fail++; $display("FAIL midreset out_last got %b exp 0", out_last2); end
        @(negedge clock);
        rst2_n = 1'b1;
        #1;
        n_checks++; if (in_ready2 !== 1'b1) begin n_fail++; $display("FAIL midreset in_ready got %b exp 1", in_ready2); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_hold_input();
        test_random();
        test_count_wrap_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
